// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmitter (and a future receiver):
//   - tx_state_t : 2-bit FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - frame constants for 8N1 framing
//   - baud_div() : clock cycles per serial bit, truncating division
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  function automatic int baud_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if
// Byte handshake between the processor-side producer and the transmitter.
//   tx_data  : byte to send, sampled only on acceptance
//   tx_valid : producer has a byte; held until accepted
//   tx_ready : transmitter holding register is empty
//   tx_busy  : a frame is in progress or a byte is held
// Modports: master = producer, slave = transmitter.
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running bit-period counter, 0..DIV-1, shared by transmitter and
// (later) receiver.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   restart : synchronous clear, holds the count at zero while asserted
//   tick    : one-cycle pulse on the last cycle of each bit period
module uart_baud_tick #(
  parameter int DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] count;

  assign tick = (count == W'(DIV - 1));

  // Wrapping on tick keeps the count inside 0..DIV-1 even when DIV is not
  // a power of two.
  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 UART transmitter with a one-byte holding register so that a queued
// byte follows the previous stop bit with no idle gap.
//   CLK         : system clock
//   RESET       : synchronous active-high reset
//   bus (slave) : tx_data / tx_valid / tx_ready / tx_busy byte handshake
//   TXD         : registered serial output, idles high
// Parameters CLK_FREQ_HZ and BAUD_RATE set DIV = CLK_FREQ_HZ / BAUD_RATE
// clock cycles per bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       CLK,
  input  logic       RESET,
  uart_tx_if.slave   bus,
  output logic       TXD
);

  localparam int DIV   = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tick;
  logic                 baud_restart;

  // Every non-IDLE state is left on a tick, where the counter wraps to zero
  // by itself, so holding it clear in IDLE is enough to start each state
  // from count zero.
  assign baud_restart = (state == IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) baud (
    .clk    (CLK),
    .rst    (RESET),
    .restart(baud_restart),
    .tick   (tick)
  );

  assign bus.tx_ready = !hold_full;
  assign bus.tx_busy  = (state != IDLE) || hold_full;

  // Holding register and frame FSM share one block. A load needs
  // hold_full=0 and a clear needs hold_full=1, so the two never collide.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      TXD       <= 1'b1;
      hold_data <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      if (bus.tx_valid && !hold_full) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          TXD <= 1'b1;
          if (hold_full) begin
            shift     <= hold_data;
            hold_full <= 1'b0;
            TXD       <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (tick) begin
            TXD     <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        // TXD takes shift[1] because it is the bit that lands in shift[0]
        // on this same edge.
        DATA: begin
          if (tick) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              TXD   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              TXD     <= shift[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        // A byte queued during the frame starts its start bit on the very
        // edge that ends this stop bit.
        STOP: begin
          if (tick) begin
            if (hold_full) begin
              shift     <= hold_data;
              hold_full <= 1'b0;
              TXD       <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          TXD   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
